// File: rtl/audio_pkg.sv
// Shared types and constants for the audio command path.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DATA_W_DEF = 64;

  localparam logic [63:0] CMD_NOTE_ON_HI = 64'h9000_0000_0000_00FF;
  localparam logic [63:0] CMD_NOTE_ON_LO = 64'h9000_0000_0000_0000;

endpackage

// File: rtl/audio_rr_picker.sv
// Round-robin winner search: first set bit of valid, scanning circularly from ptr+1.
module audio_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic               any,
  output logic [PTR_W-1:0]   winner
);

  int idx;

  // Scan farthest offset first so the nearest candidate is the last one written.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) begin
        any    = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/audio_shift_arbiter.sv
// Round-robin arbiter sharing one audio command shifter among several sources.
// state | meaning: IDLE wait for request | LOAD strobe out | WAIT_BUSY await ready low | WAIT_DONE await ready high
module audio_shift_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_grant,
  input  logic                      shft_ready,
  output logic [DATA_W-1:0]         shft_data,
  output logic                      shft_load,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GRD_W = $clog2(GUARD_CYCLES + 1);

  arb_state_t         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [GRD_W-1:0]   guard, guard_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               load_nxt, tmo_nxt;
  logic               any;
  logic [PTR_W-1:0]   winner;

  audio_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .any    (any),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      guard       <= '0;
      shft_data   <= '0;
      shft_load   <= 1'b0;
      req_grant   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      guard       <= guard_nxt;
      shft_data   <= data_nxt;
      shft_load   <= load_nxt;
      req_grant   <= grant_nxt;
      timeout_err <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    guard_nxt = guard;
    data_nxt  = shft_data;
    load_nxt  = 1'b0;
    grant_nxt = '0;
    tmo_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && shft_ready && any) begin
          data_nxt  = req_data[int'(winner)*DATA_W +: DATA_W];
          load_nxt  = 1'b1;
          grant_nxt = NUM_REQ'(1) << winner;
          rr_nxt    = winner;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        guard_nxt = '0;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A shifter that never drops ready is treated as having consumed the command.
        if (!shft_ready) begin
          state_nxt = ST_WAIT_DONE;
        end else if (guard == GRD_W'(GUARD_CYCLES - 1)) begin
          tmo_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          guard_nxt = guard + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (shft_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_audio_shift_arbiter.sv
// Directed self-checking bench for audio_shift_arbiter (4 requesters, 16-cycle guard).
module tb_audio_shift_arbiter;
  import audio_pkg::*;

  localparam logic [63:0] D0 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] D1 = 64'h2222_0000_0000_0002;
  localparam logic [63:0] D2 = CMD_NOTE_ON_HI;
  localparam logic [63:0] D3 = 64'h4444_0000_0000_0004;

  logic         clk;
  logic         rst;
  logic         en;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [3:0]   req_grant;
  logic         shft_ready;
  logic [63:0]  shft_data;
  logic         shft_load;
  logic         busy;
  logic         timeout_err;

  int n_vec = 0;
  int n_err = 0;

  assign req_data = {D3, D2, D1, D0};

  audio_shift_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_grant   (req_grant),
    .shft_ready  (shft_ready),
    .shft_data   (shft_data),
    .shft_load   (shft_load),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dval(input int i);
    case (i)
      0:       return D0;
      1:       return D1;
      2:       return D2;
      default: return D3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(req_grant), 64'h0);
    chk("rst_load", 64'(shft_load), 64'h0);
    chk("rst_data", shft_data, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_tmo", 64'(timeout_err), 64'h0);
    rst = 1'b1;
  endtask

  // One arbitration from IDLE; if a load is expected, cycle the shifter ready 1->0->1.
  task automatic do_xfer(input string nm, input logic [3:0] v, input logic e,
                         input logic [3:0] eg, input logic [63:0] ed);
    req_valid  = v;
    en         = e;
    shft_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_grant"}, 64'(req_grant), 64'(eg));
    chk({nm, "_load"}, 64'(shft_load), 64'(|eg));
    chk({nm, "_data"}, shft_data, ed);
    req_valid = 4'b0000;
    if (|eg) begin
      @(negedge clk);
      shft_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_busy_mid"}, 64'(busy), 64'h1);
      shft_ready = 1'b1;
      @(negedge clk);
    end
    chk({nm, "_idle"}, 64'(busy), 64'h0);
  endtask

  typedef struct {
    logic [3:0] v;
    logic       e;
    logic [3:0] g;
    int         di;
  } vec_t;

  vec_t vt [12];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen, last_cyc, low, tcyc;
    int order [6];

    vt[0]  = '{4'b0100, 1'b1, 4'b0100, 2};
    vt[1]  = '{4'b1111, 1'b1, 4'b1000, 3};
    vt[2]  = '{4'b1111, 1'b1, 4'b0001, 0};
    vt[3]  = '{4'b0001, 1'b1, 4'b0001, 0};
    vt[4]  = '{4'b0000, 1'b1, 4'b0000, 0};
    vt[5]  = '{4'b0001, 1'b0, 4'b0000, 0};
    vt[6]  = '{4'b1001, 1'b1, 4'b1000, 3};
    vt[7]  = '{4'b0110, 1'b1, 4'b0010, 1};
    vt[8]  = '{4'b0101, 1'b1, 4'b0100, 2};
    vt[9]  = '{4'b0011, 1'b1, 4'b0001, 0};
    vt[10] = '{4'b1000, 1'b1, 4'b1000, 3};
    vt[11] = '{4'b0000, 1'b1, 4'b0000, 3};
    order = '{0, 1, 2, 3, 0, 1};

    en = 1'b1;
    req_valid = 4'b0000;
    shft_ready = 1'b1;
    do_reset();

    // Simultaneous pair right after reset: 1, 3, 1
    do_xfer("pair_a", 4'b1010, 1'b1, 4'b0010, D1);
    do_xfer("pair_b", 4'b1010, 1'b1, 4'b1000, D3);
    do_xfer("pair_c", 4'b1010, 1'b1, 4'b0010, D1);

    do_reset();
    for (int i = 0; i < 12; i++)
      do_xfer($sformatf("vec%0d", i), vt[i].v, vt[i].e, vt[i].g, dval(vt[i].di));

    // All requesters held with a reactive shifter
    en = 1'b1;
    req_valid = 4'b1111;
    shft_ready = 1'b1;
    seen = 0;
    last_cyc = -100;
    low = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      chk("rr_load_vs_grant", 64'(shft_load), 64'(|req_grant));
      if (shft_load && seen < 6) begin
        chk($sformatf("rr_grant%0d", seen), 64'(req_grant), 64'(4'b0001 << order[seen]));
        chk($sformatf("rr_data%0d", seen), shft_data, dval(order[seen]));
        if (seen > 0) chk("rr_spacing", 64'((cyc - last_cyc) >= 4), 64'h1);
        last_cyc = cyc;
        seen++;
        shft_ready = 1'b0;
        low = 3;
        if (seen == 6) req_valid = 4'b0000;
      end else if (low > 0) begin
        low--;
        if (low == 0) shft_ready = 1'b1;
      end
      if (seen == 6 && low == 0 && !busy) break;
    end
    chk("rr_count", 64'(seen), 64'd6);
    chk("rr_idle", 64'(busy), 64'h0);

    // Shifter never drops ready: guard expires
    shft_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("tmo_grant", 64'(req_grant), 64'h1);
    chk("tmo_load", 64'(shft_load), 64'h1);
    req_valid = 4'b0000;
    tcyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        tcyc = k;
        break;
      end
    end
    chk("tmo_latency", 64'(tcyc), 64'd17);
    chk("tmo_idle", 64'(busy), 64'h0);
    @(negedge clk);
    chk("tmo_pulse_width", 64'(timeout_err), 64'h0);
    do_xfer("after_tmo", 4'b0010, 1'b1, 4'b0010, D1);

    // Enable gating
    en = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("en_off_grant", 64'(req_grant), 64'h0);
      chk("en_off_load", 64'(shft_load), 64'h0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("en_on_grant", 64'(req_grant), 64'h1);
    chk("en_on_load", 64'(shft_load), 64'h1);
    @(negedge clk);
    shft_ready = 1'b0;
    @(negedge clk);
    chk("en_wd_busy", 64'(busy), 64'h1);
    en = 1'b0;
    shft_ready = 1'b1;
    @(negedge clk);
    chk("en_drop_done", 64'(busy), 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("en_drop_nogrant", 64'(req_grant), 64'h0);
      chk("en_drop_noload", 64'(shft_load), 64'h0);
    end
    req_valid = 4'b0000;
    en = 1'b1;

    // Asynchronous reset in WAIT_DONE
    req_valid = 4'b0010;
    @(negedge clk);
    chk("mr_grant", 64'(req_grant), 64'h2);
    req_valid = 4'b0000;
    @(negedge clk);
    shft_ready = 1'b0;
    @(negedge clk);
    chk("mr_busy", 64'(busy), 64'h1);
    chk("mr_data_before", shft_data, D1);
    #1 rst = 1'b0;
    #1;
    chk("mr_async_busy", 64'(busy), 64'h0);
    chk("mr_async_load", 64'(shft_load), 64'h0);
    chk("mr_async_grant", 64'(req_grant), 64'h0);
    chk("mr_async_data", shft_data, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    shft_ready = 1'b1;
    do_xfer("post_rst", 4'b0111, 1'b1, 4'b0001, D0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_shift_arbiter.md
Name: audio_shift_arbiter

Overview:
Shares the single 64-bit audio command shifter between up to NUM_REQ command sources, e.g. the pulse generator, sound effects and music sequencer. Each source presents a valid/data pair and receives a one-cycle grant. The arbiter picks a winner round-robin, issues exactly one shft_load per command, and waits for the shifter to finish before the next load. It sits between the audio sources and the shifter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 64, shifter command width
GUARD_CYCLES, 16, max cycles to wait for shft_ready to drop after a load before declaring timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset; all state is cleared while rst==0
en  in  1  global enable; 0 blocks new grants, and an in-flight transfer still completes
req_valid  in  NUM_REQ  bit i: requester i has a command pending
req_data  in  NUM_REQ*DATA_W  requester i command at bits [i*DATA_W +: DATA_W]
req_grant  out  NUM_REQ  one-hot, one-cycle pulse: requester i's command was taken
shft_ready  in  1  shifter idle and able to accept a load
shft_data  out  DATA_W  command to shifter, registered, held stable between loads
shft_load  out  1  one-cycle load strobe to the shifter
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse when the WAIT_BUSY guard expires

Behaviour:
- Reset values: state=IDLE, shft_data=0, shft_load=0, req_grant=0, timeout_err=0, rr_ptr=NUM_REQ-1 (so requester 0 wins first), guard counter=0.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE: if en && shft_ready && |req_valid, then:
  - Winner = first set bit of req_valid, searching circularly from rr_ptr+1.
  - Next edge: shft_data<=req_data[winner], shft_load<=1, req_grant[winner]<=1, rr_ptr<=winner, state<=LOAD.
  - Otherwise remain in IDLE and keep outputs low.
- LOAD (one cycle): shft_load and req_grant are high in this cycle only. Clear the guard counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - If shft_ready==0, go to WAIT_DONE.
  - Otherwise increment the guard counter.
  - When the counter reaches GUARD_CYCLES-1 with shft_ready still 1: pulse timeout_err for one cycle and return to IDLE. The command counts as delivered and is not reissued.
- WAIT_DONE: when shft_ready==1, return to IDLE. There is no timeout in this state.
- Latency: valid and ready sampled high in IDLE at edge N gives shft_load/grant high in cycle N+1. Minimum spacing between loads is 4 cycles.
- req_valid and req_data are sampled only in IDLE. A requester must deassert valid, or present its next command, in the cycle after it sees its grant.
- Simultaneous requests: only one grant per arbitration. Losers stay pending and win in round-robin order. With all requests held high, the grant order is 0,1,...,NUM_REQ-1,0.
- A requester that drops valid before being granted is simply skipped. No state is kept per requester.
- en falling mid-transfer: the FSM runs to IDLE and then stalls there. shft_data holds its last value.
- Reset asserted mid-transfer: everything returns to reset values immediately and asynchronously. shft_load drops without a completion handshake.
- shft_data changes only on the LOAD entry edge and on reset.

Decomposition:
- Shared package audio_pkg holds:
  - the FSM state encoding;
  - the DATA_W default of 64;
  - the audio command constants (note-on-high 64'h9000_0000_0000_00FF, note-on-low 64'h9000_0000_0000_0000).
- One combinational sub-module, audio_rr_picker, takes (req_valid, rr_ptr) and returns (any, winner index). It is reusable by other audio arbiters.

Test Plan:
- Reset, then req_valid=4'b0100, data=64'h9000_0000_0000_00FF, shft_ready=1 -> grant=4'b0100 and shft_load in the same single cycle one edge later; shft_data=64'h9000_0000_0000_00FF; busy until the shifter cycles ready 1->0->1.
- req_valid=4'b1111 held, shifter model drops ready 1 cycle after load for 10 cycles -> grants in order 0,1,2,3,0,1; exactly one shft_load per grant; loads at least 4 cycles apart.
- req_valid=4'b1010 simultaneously after reset -> requester 1 granted first, then 3, then 1.
- Shifter keeps shft_ready=1 after a load -> timeout_err pulses exactly GUARD_CYCLES cycles after WAIT_BUSY entry; FSM returns to IDLE; the next request is granted normally.
- en=0 with req_valid=4'b0001 -> no grant or load. Raise en -> grant on the next edge. Drop en during WAIT_DONE -> the transfer completes and no new grant follows.
- Assert rst=0 during WAIT_DONE -> state, shft_load, req_grant and shft_data go to 0 without waiting for a clock. After release, requester 0 has priority again.
